// File: rtl/lif_neuron_array.sv
// N_CH leaky integrate-and-fire neurons, time-multiplexed: one channel evaluated per cycle per tick scan.
// Tick-to-vec_valid latency N_CH+1 cycles; in_ready is low for the whole scan, so inputs stall (never dropped).
module lif_neuron_array #(
    parameter int N_CH       = 4,
    parameter int W          = 8,
    parameter int R_W        = 4,
    parameter int THRESH_RST = 100,
    parameter int CH_W       = $clog2(N_CH)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            cfg_we,
    input  logic [W-1:0]    cfg_thresh,
    input  logic [2:0]      cfg_leak,
    input  logic [R_W-1:0]  cfg_refrac,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [CH_W-1:0] in_ch,
    input  logic [W-1:0]    in_current,
    input  logic            tick,
    output logic            busy,
    output logic            spike_pulse,
    output logic [CH_W-1:0] spike_ch,
    output logic            vec_valid,
    output logic [N_CH-1:0] spike_vec,
    output logic            tick_overrun,
    input  logic [CH_W-1:0] dbg_ch,
    output logic [W-1:0]    dbg_mem
);

    typedef enum logic {IDLE = 1'b0, SCAN = 1'b1} state_t;

    localparam logic [CH_W-1:0] K_LAST = CH_W'(N_CH - 1);

    state_t          state, state_nxt;
    logic [CH_W-1:0] k;
    logic [W-1:0]    mem    [N_CH];
    logic [R_W-1:0]  refrac [N_CH];
    logic [W-1:0]    thresh_q;
    logic [2:0]      leak_q;
    logic [R_W-1:0]  refrac_q;
    logic [N_CH-1:0] shadow;

    logic            scan_start, scan_last;
    logic            accept, in_ch_ok;
    logic [W:0]      sum;
    logic [W-1:0]    sat;
    logic [W-1:0]    cur_mem, leaked;
    logic [R_W-1:0]  cur_ref;
    logic            in_refrac, fire;
    logic [N_CH-1:0] fire_vec;

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt  = state;
        in_ready   = 1'b0;
        busy       = 1'b0;
        scan_start = 1'b0;
        scan_last  = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (tick) begin
                    state_nxt  = SCAN;
                    scan_start = 1'b1;
                end
            end
            SCAN: begin
                busy = 1'b1;
                if (k == K_LAST) begin
                    state_nxt = IDLE;
                    scan_last = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Integration saturates at all-ones; computed one bit wider to catch the carry.
    always_comb begin
        in_ch_ok = int'(in_ch) < N_CH;
        accept   = in_valid && in_ready && in_ch_ok;
        sum      = {1'b0, mem[in_ch]} + {1'b0, in_current};
        sat      = sum[W] ? '1 : sum[W-1:0];
    end

    always_comb begin
        cur_mem     = mem[k];
        cur_ref     = refrac[k];
        leaked      = (leak_q == 3'd0) ? cur_mem : cur_mem - (cur_mem >> leak_q);
        in_refrac   = cur_ref != '0;
        fire        = !in_refrac && (leaked >= thresh_q);
        fire_vec    = '0;
        fire_vec[k] = fire;
    end

    always_comb begin
        dbg_mem = '0;
        if (int'(dbg_ch) < N_CH) dbg_mem = mem[dbg_ch];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < N_CH; i++) begin
                mem[i]    <= '0;
                refrac[i] <= '0;
            end
            k            <= '0;
            thresh_q     <= W'(THRESH_RST);
            leak_q       <= 3'd1;
            refrac_q     <= '0;
            shadow       <= '0;
            spike_pulse  <= 1'b0;
            spike_ch     <= '0;
            vec_valid    <= 1'b0;
            spike_vec    <= '0;
            tick_overrun <= 1'b0;
        end else begin
            spike_pulse <= 1'b0;
            vec_valid   <= 1'b0;

            if (cfg_we) begin
                thresh_q <= cfg_thresh;
                leak_q   <= cfg_leak;
                refrac_q <= cfg_refrac;
            end

            if (busy && tick) tick_overrun <= 1'b1;

            // Refractory channels swallow their input current.
            if (accept && (refrac[in_ch] == '0)) mem[in_ch] <= sat;

            if (scan_start) begin
                k      <= '0;
                shadow <= '0;
            end

            if (busy) begin
                if (in_refrac) begin
                    refrac[k] <= cur_ref - R_W'(1);
                    mem[k]    <= '0;
                end else if (fire) begin
                    mem[k]      <= '0;
                    refrac[k]   <= refrac_q;
                    spike_pulse <= 1'b1;
                    spike_ch    <= k;
                end else begin
                    mem[k] <= leaked;
                end
                shadow <= shadow | fire_vec;
                k      <= k + CH_W'(1);
                if (scan_last) begin
                    vec_valid <= 1'b1;
                    spike_vec <= shadow | fire_vec;
                end
            end
        end
    end

endmodule

// File: tb/tb_lif_neuron_array.sv
// Directed bench for lif_neuron_array: vector table plus hand sequences for reset, collisions and overrun.
`timescale 1ns/1ps
module tb_lif_neuron_array;

    localparam int N_CH = 4;
    localparam int W    = 8;
    localparam int R_W  = 4;
    localparam int CH_W = 2;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            cfg_we = 1'b0;
    logic [W-1:0]    cfg_thresh = '0;
    logic [2:0]      cfg_leak = '0;
    logic [R_W-1:0]  cfg_refrac = '0;
    logic            in_valid = 1'b0;
    logic            in_ready;
    logic [CH_W-1:0] in_ch = '0;
    logic [W-1:0]    in_current = '0;
    logic            tick = 1'b0;
    logic            busy;
    logic            spike_pulse;
    logic [CH_W-1:0] spike_ch;
    logic            vec_valid;
    logic [N_CH-1:0] spike_vec;
    logic            tick_overrun;
    logic [CH_W-1:0] dbg_ch = '0;
    logic [W-1:0]    dbg_mem;

    int n_vec = 0;
    int n_err = 0;

    always #10 clk = ~clk;

    lif_neuron_array #(.N_CH(N_CH), .W(W), .R_W(R_W), .THRESH_RST(100)) dut (
        .clk(clk), .rst(rst),
        .cfg_we(cfg_we), .cfg_thresh(cfg_thresh), .cfg_leak(cfg_leak), .cfg_refrac(cfg_refrac),
        .in_valid(in_valid), .in_ready(in_ready), .in_ch(in_ch), .in_current(in_current),
        .tick(tick), .busy(busy), .spike_pulse(spike_pulse), .spike_ch(spike_ch),
        .vec_valid(vec_valid), .spike_vec(spike_vec), .tick_overrun(tick_overrun),
        .dbg_ch(dbg_ch), .dbg_mem(dbg_mem)
    );

    typedef struct {
        logic [W-1:0]    th;
        logic [2:0]      lk;
        logic [R_W-1:0]  rf;
        int              ch;
        logic [W-1:0]    cur;
        bit              tk;
        logic [W-1:0]    exp_mem;
        logic [N_CH-1:0] exp_vec;
    } vec_t;

    vec_t tv [19];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic read_mem(input int ch, output logic [W-1:0] v);
        dbg_ch = CH_W'(ch);
        #1;
        v = dbg_mem;
    endtask

    task automatic set_cfg(input logic [W-1:0] th, input logic [2:0] lk, input logic [R_W-1:0] rf);
        cfg_we = 1'b1; cfg_thresh = th; cfg_leak = lk; cfg_refrac = rf;
        step();
        cfg_we = 1'b0;
    endtask

    task automatic put(input int ch, input logic [W-1:0] cur);
        in_valid = 1'b1; in_ch = CH_W'(ch); in_current = cur;
        step();
        in_valid = 1'b0;
    endtask

    // Launches one tick and watches a bounded window; c counts cycles after the tick was sampled.
    task automatic run_scan(output logic [N_CH-1:0] pulses, output logic [N_CH-1:0] vec,
                            output int lat, output int pc);
        pulses = '0; vec = '0; lat = -1; pc = -1;
        tick = 1'b1;
        step();
        tick = 1'b0;
        for (int c = 1; c <= N_CH + 3; c++) begin
            if (spike_pulse) begin
                pulses[spike_ch] = 1'b1;
                if (pc < 0) pc = c;
            end
            if (vec_valid && lat < 0) begin
                lat = c;
                vec = spike_vec;
            end
            step();
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [N_CH-1:0] pulses, vec;
        logic [W-1:0]    m;
        int              lat, pc, lowest;

        //           th   lk  rf  ch  cur  tk  mem  vec
        tv[0]  = '{8'd100, 3'd0, 4'd0, 2, 8'd60,  1'b0, 8'd60,  4'b0000};
        tv[1]  = '{8'd100, 3'd0, 4'd0, 2, 8'd60,  1'b0, 8'd120, 4'b0000};
        tv[2]  = '{8'd100, 3'd0, 4'd0, 2, 8'd0,   1'b1, 8'd0,   4'b0100};
        tv[3]  = '{8'd255, 3'd0, 4'd0, 0, 8'd200, 1'b0, 8'd200, 4'b0000};
        tv[4]  = '{8'd255, 3'd0, 4'd0, 0, 8'd200, 1'b0, 8'd255, 4'b0000};
        tv[5]  = '{8'd255, 3'd0, 4'd0, 0, 8'd0,   1'b1, 8'd0,   4'b0001};
        tv[6]  = '{8'd100, 3'd2, 4'd0, 1, 8'd80,  1'b0, 8'd80,  4'b0000};
        tv[7]  = '{8'd100, 3'd2, 4'd0, 1, 8'd0,   1'b1, 8'd60,  4'b0000};
        tv[8]  = '{8'd100, 3'd2, 4'd0, 1, 8'd0,   1'b1, 8'd45,  4'b0000};
        tv[9]  = '{8'd100, 3'd0, 4'd2, 3, 8'd150, 1'b0, 8'd150, 4'b0000};
        tv[10] = '{8'd100, 3'd0, 4'd2, 3, 8'd0,   1'b1, 8'd0,   4'b1000};
        tv[11] = '{8'd100, 3'd0, 4'd2, 3, 8'd150, 1'b0, 8'd0,   4'b0000};
        tv[12] = '{8'd100, 3'd0, 4'd2, 3, 8'd0,   1'b1, 8'd0,   4'b0000};
        tv[13] = '{8'd100, 3'd0, 4'd2, 3, 8'd150, 1'b0, 8'd0,   4'b0000};
        tv[14] = '{8'd100, 3'd0, 4'd2, 3, 8'd0,   1'b1, 8'd0,   4'b0000};
        tv[15] = '{8'd100, 3'd0, 4'd2, 3, 8'd150, 1'b0, 8'd150, 4'b0000};
        tv[16] = '{8'd100, 3'd0, 4'd2, 3, 8'd0,   1'b1, 8'd0,   4'b1000};
        tv[17] = '{8'd0,   3'd0, 4'd0, 1, 8'd0,   1'b1, 8'd0,   4'b0111};
        tv[18] = '{8'd0,   3'd0, 4'd0, 3, 8'd0,   1'b1, 8'd0,   4'b0111};

        // Reset state
        rst = 1'b1;
        step(); step();
        chk("rst_in_ready", in_ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_spike_vec", spike_vec, 0);
        chk("rst_overrun", tick_overrun, 0);
        chk("rst_vec_valid", vec_valid, 0);
        chk("rst_spike_pulse", spike_pulse, 0);
        for (int c = 0; c < N_CH; c++) begin
            read_mem(c, m);
            chk($sformatf("rst_mem%0d", c), m, 0);
        end
        rst = 1'b0;
        step();

        // Reset config is thresh 100, leak 1: 100 leaks to 50 without firing
        put(0, 8'd100);
        run_scan(pulses, vec, lat, pc);
        chk("dflt_vec", vec, 0);
        read_mem(0, m);
        chk("dflt_leak_mem0", m, 50);
        rst = 1'b1;
        step(); step();
        rst = 1'b0;
        step();
        read_mem(0, m);
        chk("rerst_mem0", m, 0);

        for (int i = 0; i < 19; i++) begin
            set_cfg(tv[i].th, tv[i].lk, tv[i].rf);
            if (tv[i].cur != '0) put(tv[i].ch, tv[i].cur);
            if (tv[i].tk) begin
                run_scan(pulses, vec, lat, pc);
                chk($sformatf("v%0d_vec_lat", i), lat, N_CH + 1);
                chk($sformatf("v%0d_spike_vec", i), vec, tv[i].exp_vec);
                chk($sformatf("v%0d_pulses", i), pulses, tv[i].exp_vec);
                if (tv[i].exp_vec != '0) begin
                    lowest = -1;
                    for (int b = N_CH - 1; b >= 0; b--)
                        if (tv[i].exp_vec[b]) lowest = b;
                    chk($sformatf("v%0d_pulse_cyc", i), pc, 2 + lowest);
                end
            end
            read_mem(tv[i].ch, m);
            chk($sformatf("v%0d_mem", i), m, tv[i].exp_mem);
        end

        // Tick with same-cycle input, overrun tick, input held through the scan
        set_cfg(8'd100, 3'd0, 4'd0);
        in_valid = 1'b1; in_ch = 2'd0; in_current = 8'd120; tick = 1'b1;
        step();
        in_valid = 1'b0; tick = 1'b0;
        for (int c = 1; c <= N_CH + 2; c++) begin
            if (c == 1) begin
                chk("coll_busy", busy, 1);
                chk("coll_in_ready", in_ready, 0);
            end
            if (c == 2) begin
                chk("coll_pulse", spike_pulse, 1);
                chk("coll_pulse_ch", spike_ch, 0);
                tick = 1'b1;
                in_valid = 1'b1; in_ch = 2'd1; in_current = 8'd30;
            end
            if (c == 3) begin
                tick = 1'b0;
                chk("coll_overrun", tick_overrun, 1);
                chk("coll_stall", in_ready, 0);
            end
            if (c == N_CH + 1) begin
                chk("coll_vec_valid", vec_valid, 1);
                chk("coll_spike_vec", spike_vec, 4'b0001);
                chk("coll_ready_back", in_ready, 1);
                read_mem(1, m);
                chk("coll_no_early_accept", m, 0);
            end
            if (c == N_CH + 2) begin
                in_valid = 1'b0;
                chk("coll_no_rescan", busy, 0);
                read_mem(1, m);
                chk("coll_late_accept", m, 30);
                chk("coll_overrun_sticky", tick_overrun, 1);
            end
            step();
        end

        // Reset in the middle of a scan
        put(2, 8'd50);
        tick = 1'b1;
        step();
        tick = 1'b0;
        step();
        rst = 1'b1;
        step();
        chk("mrst_busy", busy, 0);
        chk("mrst_in_ready", in_ready, 1);
        chk("mrst_overrun", tick_overrun, 0);
        chk("mrst_spike_vec", spike_vec, 0);
        for (int c = 0; c < N_CH; c++) begin
            read_mem(c, m);
            chk($sformatf("mrst_mem%0d", c), m, 0);
        end
        rst = 1'b0;
        step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
